// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared constants and state types for the UART command sequencer
package uart_ctrl_pkg;

  // Command codes, as received in the first byte of a frame
  localparam logic [7:0] CMD_REG_WR   = 8'hAA;
  localparam logic [7:0] CMD_REG_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPS  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOPS = 8'hDD;

  // Register-file locations that hold the ALU operands
  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  // Response lengths in bytes
  localparam int               RESP_CNT_W   = 2;
  localparam logic [1:0]       RESP_LEN_RD  = 2'd1;
  localparam logic [1:0]       RESP_LEN_ALU = 2'd2;

  // Main sequencer states
  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_SEND
  } ctrl_state_e;

  // Byte sender states
  typedef enum logic [1:0] {
    SND_IDLE,
    SND_WAIT_FREE,
    SND_WAIT_ACCEPT,
    SND_WAIT_RELEASE
  } snd_state_e;

endpackage

// File: rtl/ctrl_tx_sender.sv
// rtl/ctrl_tx_sender.sv - byte sequencer that feeds a response buffer into the UART TX
module ctrl_tx_sender
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_start,
  input  logic [RESP_CNT_W-1:0]   i_len,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic                    i_tx_busy,
  output logic [DATA_WIDTH-1:0]   o_tx_p_data,
  output logic                    o_tx_d_valid,
  output logic                    o_done
);

  snd_state_e              r_state;
  snd_state_e              w_state_n;
  logic [2*DATA_WIDTH-1:0] r_buf;
  logic [2*DATA_WIDTH-1:0] w_buf_n;
  logic [RESP_CNT_W-1:0]   r_left;
  logic [RESP_CNT_W-1:0]   w_left_n;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic [DATA_WIDTH-1:0]   w_tx_data_n;
  logic                    r_tx_valid;
  logic                    w_tx_valid_n;
  logic                    r_done;
  logic                    w_done_n;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= SND_IDLE;
      r_buf      <= '0;
      r_left     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_buf      <= w_buf_n;
      r_left     <= w_left_n;
      r_tx_data  <= w_tx_data_n;
      r_tx_valid <= w_tx_valid_n;
      r_done     <= w_done_n;
    end
  end

  // Next state: send LSB first, then require a busy rise and fall before the next byte
  always_comb begin
    w_state_n    = r_state;
    w_buf_n      = r_buf;
    w_left_n     = r_left;
    w_tx_data_n  = r_tx_data;
    w_tx_valid_n = 1'b0;
    w_done_n     = 1'b0;
    case (r_state)
      SND_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_done_n = 1'b1;
          end else begin
            w_buf_n   = i_data;
            w_left_n  = i_len;
            w_state_n = SND_WAIT_FREE;
          end
        end
      end
      SND_WAIT_FREE: begin
        if (!i_tx_busy) begin
          w_tx_data_n  = r_buf[DATA_WIDTH-1:0];
          w_tx_valid_n = 1'b1;
          w_buf_n      = r_buf >> DATA_WIDTH;
          w_left_n     = r_left - 1'b1;
          if (r_left == RESP_CNT_W'(1)) begin
            w_done_n  = 1'b1;
            w_state_n = SND_IDLE;
          end else begin
            w_state_n = SND_WAIT_ACCEPT;
          end
        end
      end
      SND_WAIT_ACCEPT: begin
        if (i_tx_busy) w_state_n = SND_WAIT_RELEASE;
      end
      SND_WAIT_RELEASE: begin
        if (!i_tx_busy) w_state_n = SND_WAIT_FREE;
      end
      default: w_state_n = SND_IDLE;
    endcase
  end

  assign o_tx_p_data  = r_tx_data;
  assign o_tx_d_valid = r_tx_valid;
  assign o_done       = r_done;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command sequencer for register-file and ALU access
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    rf_rd_en,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_valid,
  input  logic                    tx_busy,
  output logic                    cmd_error
);

  ctrl_state_e             r_state;
  ctrl_state_e             w_state_n;
  logic [ADDR_WIDTH-1:0]   r_rf_addr;
  logic [ADDR_WIDTH-1:0]   w_rf_addr_n;
  logic                    r_rf_wr_en;
  logic                    w_rf_wr_en_n;
  logic [DATA_WIDTH-1:0]   r_rf_wr_data;
  logic [DATA_WIDTH-1:0]   w_rf_wr_data_n;
  logic                    r_rf_rd_en;
  logic                    w_rf_rd_en_n;
  logic                    r_alu_en;
  logic                    w_alu_en_n;
  logic [FUN_WIDTH-1:0]    r_alu_fun;
  logic [FUN_WIDTH-1:0]    w_alu_fun_n;
  logic                    r_clk_gate_en;
  logic                    w_clk_gate_en_n;
  logic                    r_cmd_error;
  logic                    w_cmd_error_n;
  logic                    r_tx_start;
  logic                    w_tx_start_n;
  logic [RESP_CNT_W-1:0]   r_tx_len;
  logic [RESP_CNT_W-1:0]   w_tx_len_n;
  logic [2*DATA_WIDTH-1:0] r_tx_buf;
  logic [2*DATA_WIDTH-1:0] w_tx_buf_n;
  logic                    w_tx_done;

  // State and registered outputs; reset abandons any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_rf_addr     <= '0;
      r_rf_wr_en    <= 1'b0;
      r_rf_wr_data  <= '0;
      r_rf_rd_en    <= 1'b0;
      r_alu_en      <= 1'b0;
      r_alu_fun     <= '0;
      r_clk_gate_en <= 1'b0;
      r_cmd_error   <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_len      <= '0;
      r_tx_buf      <= '0;
    end else begin
      r_state       <= w_state_n;
      r_rf_addr     <= w_rf_addr_n;
      r_rf_wr_en    <= w_rf_wr_en_n;
      r_rf_wr_data  <= w_rf_wr_data_n;
      r_rf_rd_en    <= w_rf_rd_en_n;
      r_alu_en      <= w_alu_en_n;
      r_alu_fun     <= w_alu_fun_n;
      r_clk_gate_en <= w_clk_gate_en_n;
      r_cmd_error   <= w_cmd_error_n;
      r_tx_start    <= w_tx_start_n;
      r_tx_len      <= w_tx_len_n;
      r_tx_buf      <= w_tx_buf_n;
    end
  end

  // Frame parsing and next-cycle strobes; held values default to their current contents
  always_comb begin
    w_state_n       = r_state;
    w_rf_addr_n     = r_rf_addr;
    w_rf_wr_en_n    = 1'b0;
    w_rf_wr_data_n  = r_rf_wr_data;
    w_rf_rd_en_n    = 1'b0;
    w_alu_en_n      = 1'b0;
    w_alu_fun_n     = r_alu_fun;
    w_clk_gate_en_n = r_clk_gate_en;
    w_cmd_error_n   = 1'b0;
    w_tx_start_n    = 1'b0;
    w_tx_len_n      = r_tx_len;
    w_tx_buf_n      = r_tx_buf;
    case (r_state)
      IDLE: begin
        if (rx_d_valid) begin
          if (rx_p_data == DATA_WIDTH'(CMD_REG_WR))        w_state_n = WR_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_REG_RD))   w_state_n = RD_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OPS))  w_state_n = ALU_A;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOPS)) w_state_n = ALU_FUN;
          else                                             w_cmd_error_n = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_d_valid) begin
          w_rf_addr_n = rx_p_data[ADDR_WIDTH-1:0];
          w_state_n   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_d_valid) begin
          w_rf_wr_en_n   = 1'b1;
          w_rf_wr_data_n = rx_p_data;
          w_state_n      = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_d_valid) begin
          w_rf_addr_n  = rx_p_data[ADDR_WIDTH-1:0];
          w_rf_rd_en_n = 1'b1;
          w_state_n    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid) begin
          w_tx_buf_n   = {{DATA_WIDTH{1'b0}}, rf_rd_data};
          w_tx_len_n   = RESP_LEN_RD;
          w_tx_start_n = 1'b1;
          w_state_n    = TX_SEND;
        end
      end
      ALU_A: begin
        if (rx_d_valid) begin
          w_rf_addr_n    = ADDR_WIDTH'(ALU_A_ADDR);
          w_rf_wr_en_n   = 1'b1;
          w_rf_wr_data_n = rx_p_data;
          w_state_n      = ALU_B;
        end
      end
      ALU_B: begin
        if (rx_d_valid) begin
          w_rf_addr_n    = ADDR_WIDTH'(ALU_B_ADDR);
          w_rf_wr_en_n   = 1'b1;
          w_rf_wr_data_n = rx_p_data;
          w_state_n      = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (rx_d_valid) begin
          w_alu_fun_n     = rx_p_data[FUN_WIDTH-1:0];
          w_alu_en_n      = 1'b1;
          w_clk_gate_en_n = 1'b1;
          w_state_n       = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_out_valid) begin
          w_clk_gate_en_n = 1'b0;
          w_tx_buf_n      = alu_out;
          w_tx_len_n      = RESP_LEN_ALU;
          w_tx_start_n    = 1'b1;
          w_state_n       = TX_SEND;
        end
      end
      TX_SEND: begin
        if (w_tx_done) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    // A byte arriving while a response is pending is dropped and flagged
    if (rx_d_valid && (r_state == RD_WAIT || r_state == ALU_WAIT || r_state == TX_SEND))
      w_cmd_error_n = 1'b1;
  end

  ctrl_tx_sender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_sender (
    .CLK          (CLK),
    .RST          (RST),
    .i_start      (r_tx_start),
    .i_len        (r_tx_len),
    .i_data       (r_tx_buf),
    .i_tx_busy    (tx_busy),
    .o_tx_p_data  (tx_p_data),
    .o_tx_d_valid (tx_d_valid),
    .o_done       (w_tx_done)
  );

  assign rf_addr     = r_rf_addr;
  assign rf_wr_en    = r_rf_wr_en;
  assign rf_wr_data  = r_rf_wr_data;
  assign rf_rd_en    = r_rf_rd_en;
  assign alu_en      = r_alu_en;
  assign alu_fun     = r_alu_fun;
  assign clk_gate_en = r_clk_gate_en;
  assign cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for the UART command sequencer
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_valid;
  logic        tx_busy = 1'b0;
  logic        cmd_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_wr = 0, cnt_rd = 0, cnt_tx = 0, cnt_err = 0, cnt_alu = 0;
  int base_wr, base_rd, base_tx, base_err, base_alu;

  always #5 CLK = ~CLK;

  uart_cmd_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_p_data     (rx_p_data),
    .rx_d_valid    (rx_d_valid),
    .rf_addr       (rf_addr),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_data    (rf_wr_data),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_data    (rf_rd_data),
    .rf_rd_valid   (rf_rd_valid),
    .alu_en        (alu_en),
    .alu_fun       (alu_fun),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .clk_gate_en   (clk_gate_en),
    .tx_p_data     (tx_p_data),
    .tx_d_valid    (tx_d_valid),
    .tx_busy       (tx_busy),
    .cmd_error     (cmd_error)
  );

  // Strobe counters sampled away from the active edge
  always @(negedge CLK) begin
    if (rf_wr_en)   cnt_wr  <= cnt_wr + 1;
    if (rf_rd_en)   cnt_rd  <= cnt_rd + 1;
    if (tx_d_valid) cnt_tx  <= cnt_tx + 1;
    if (cmd_error)  cnt_err <= cnt_err + 1;
    if (alu_en)     cnt_alu <= cnt_alu + 1;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       exp_wr;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_p_data  = b;
    rx_d_valid = 1'b1;
    @(negedge CLK);
    rx_d_valid = 1'b0;
  endtask

  task automatic snap();
    base_wr = cnt_wr; base_rd = cnt_rd; base_tx = cnt_tx;
    base_err = cnt_err; base_alu = cnt_alu;
  endtask

  task automatic wait_tx(input string nm, input logic [7:0] exp);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (tx_d_valid) seen = 1;
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk(nm, 32'(tx_p_data), 32'(exp));
  endtask

  task automatic uart_accept();
    tx_busy = 1'b1;
    cycles(3);
    tx_busy = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun,
                clk_gate_en, tx_p_data, tx_d_valid, cmd_error});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'hAA, 8'h05, 8'h3C, 3, 1'b1, 4'h5, 8'h3C, 1'b0};
    vec[1] = '{8'hAA, 8'h0F, 8'hFF, 3, 1'b1, 4'hF, 8'hFF, 1'b0};
    vec[2] = '{8'hAA, 8'h13, 8'h00, 3, 1'b1, 4'h3, 8'h00, 1'b0};
    vec[3] = '{8'hAA, 8'h02, 8'hAA, 3, 1'b1, 4'h2, 8'hAA, 1'b0};
    vec[4] = '{8'h7F, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h00, 1'b1};
    vec[5] = '{8'h00, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h00, 1'b1};

    cycles(3);
    chk("reset_outputs", all_outs(), 32'd0);
    RST = 1'b0;
    cycles(2);

    // Table: register writes and unknown codes
    for (int i = 0; i < NV; i++) begin
      snap();
      send_byte(vec[i].b0);
      if (vec[i].n > 1) send_byte(vec[i].b1);
      if (vec[i].n > 2) send_byte(vec[i].b2);
      chk($sformatf("v%0d_wr_en", i), 32'(rf_wr_en), 32'(vec[i].exp_wr));
      if (vec[i].exp_wr) begin
        chk($sformatf("v%0d_addr", i), 32'(rf_addr), 32'(vec[i].exp_addr));
        chk($sformatf("v%0d_data", i), 32'(rf_wr_data), 32'(vec[i].exp_data));
      end
      chk($sformatf("v%0d_err", i), 32'(cmd_error), 32'(vec[i].exp_err));
      @(negedge CLK);
      chk($sformatf("v%0d_wr_drop", i), 32'(rf_wr_en), 32'd0);
      chk($sformatf("v%0d_err_drop", i), 32'(cmd_error), 32'd0);
      cycles(2);
      chk($sformatf("v%0d_wr_cnt", i), 32'(cnt_wr - base_wr), 32'(vec[i].exp_wr));
      chk($sformatf("v%0d_err_cnt", i), 32'(cnt_err - base_err), 32'(vec[i].exp_err));
      chk($sformatf("v%0d_tx_cnt", i), 32'(cnt_tx - base_tx), 32'd0);
    end

    // Register read, TX held busy until after the data returns
    snap();
    tx_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("rd_en", 32'(rf_rd_en), 32'd1);
    chk("rd_addr", 32'(rf_addr), 32'd5);
    @(negedge CLK);
    chk("rd_en_drop", 32'(rf_rd_en), 32'd0);
    cycles(2);
    rf_rd_data  = 8'h3C;
    rf_rd_valid = 1'b1;
    @(negedge CLK);
    rf_rd_valid = 1'b0;
    cycles(5);
    chk("rd_tx_held_busy", 32'(cnt_tx - base_tx), 32'd0);
    tx_busy = 1'b0;
    wait_tx("rd_tx_byte", 8'h3C);
    uart_accept();
    cycles(3);
    chk("rd_tx_cnt", 32'(cnt_tx - base_tx), 32'd1);
    chk("rd_rd_cnt", 32'(cnt_rd - base_rd), 32'd1);
    chk("rd_wr_cnt", 32'(cnt_wr - base_wr), 32'd0);

    // ALU with operands, plus an overrun byte while the ALU works
    snap();
    send_byte(8'hCC);
    send_byte(8'h12);
    chk("alu_wa_en", 32'(rf_wr_en), 32'd1);
    chk("alu_wa_addr", 32'(rf_addr), 32'd0);
    chk("alu_wa_data", 32'(rf_wr_data), 32'h12);
    send_byte(8'h34);
    chk("alu_wb_en", 32'(rf_wr_en), 32'd1);
    chk("alu_wb_addr", 32'(rf_addr), 32'd1);
    chk("alu_wb_data", 32'(rf_wr_data), 32'h34);
    send_byte(8'h02);
    chk("alu_en", 32'(alu_en), 32'd1);
    chk("alu_fun", 32'(alu_fun), 32'd2);
    chk("alu_gate_rise", 32'(clk_gate_en), 32'd1);
    @(negedge CLK);
    chk("alu_en_drop", 32'(alu_en), 32'd0);
    send_byte(8'h55);
    chk("alu_overrun_err", 32'(cmd_error), 32'd1);
    chk("alu_gate_hold", 32'(clk_gate_en), 32'd1);
    cycles(2);
    alu_out       = 16'h0246;
    alu_out_valid = 1'b1;
    @(negedge CLK);
    alu_out_valid = 1'b0;
    chk("alu_gate_drop", 32'(clk_gate_en), 32'd0);
    wait_tx("alu_tx_lsb", 8'h46);
    cycles(5);
    chk("alu_tx_wait_accept", 32'(cnt_tx - base_tx), 32'd1);
    tx_busy = 1'b1;
    cycles(4);
    chk("alu_tx_wait_release", 32'(cnt_tx - base_tx), 32'd1);
    tx_busy = 1'b0;
    wait_tx("alu_tx_msb", 8'h02);
    uart_accept();
    cycles(3);
    chk("alu_tx_cnt", 32'(cnt_tx - base_tx), 32'd2);
    chk("alu_wr_cnt", 32'(cnt_wr - base_wr), 32'd2);
    chk("alu_err_cnt", 32'(cnt_err - base_err), 32'd1);
    chk("alu_en_cnt", 32'(cnt_alu - base_alu), 32'd1);

    // ALU without operands
    snap();
    send_byte(8'hDD);
    send_byte(8'h13);
    chk("nop_alu_en", 32'(alu_en), 32'd1);
    chk("nop_alu_fun", 32'(alu_fun), 32'd3);
    cycles(2);
    alu_out       = 16'h00FF;
    alu_out_valid = 1'b1;
    @(negedge CLK);
    alu_out_valid = 1'b0;
    wait_tx("nop_tx_lsb", 8'hFF);
    uart_accept();
    wait_tx("nop_tx_msb", 8'h00);
    uart_accept();
    cycles(3);
    chk("nop_wr_cnt", 32'(cnt_wr - base_wr), 32'd0);

    // Reset in the middle of a write frame
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge CLK);
    RST = 1'b1;
    cycles(2);
    chk("midreset_outputs", all_outs(), 32'd0);
    RST = 1'b0;
    cycles(2);
    snap();
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("post_rst_rd_en", 32'(rf_rd_en), 32'd1);
    chk("post_rst_rd_addr", 32'(rf_addr), 32'd5);
    cycles(2);
    rf_rd_data  = 8'h77;
    rf_rd_valid = 1'b1;
    @(negedge CLK);
    rf_rd_valid = 1'b0;
    wait_tx("post_rst_tx", 8'h77);
    uart_accept();
    cycles(3);
    chk("post_rst_wr_cnt", 32'(cnt_wr - base_wr), 32'd0);
    chk("post_rst_err_cnt", 32'(cnt_err - base_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
